// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared PC-path types, constants and the branch-target helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } seq_state_t;

  // Offset is a word count; the byte target wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base,
                                                    input logic [PC_W-1:0] off);
    return base + (off << 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_next_pc_mux.sv
// ============================================================================
// Module   : next_pc_mux
// Purpose  : Combinational next-PC select: jr > jump > branch > stall > seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module next_pc_mux
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = PC_W
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_base_i,
  input  logic [WIDTH-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_index_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             redirect_o,
  output logic             misalign_o
);

  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jr_tgt;

  // J-type targets keep the 256 MB region of the delay-slot address.
  generate
    if (WIDTH > 28) begin : g_jump_region
      assign jump_tgt = {pc_plus4_i[WIDTH-1:28], jump_index_i, 2'b00};
    end else begin : g_jump_flat
      assign jump_tgt = {jump_index_i, 2'b00};
    end
  endgenerate

  generate
    if (WIDTH == PC_W) begin : g_branch_pkg
      assign branch_tgt = branch_target(branch_base_i, branch_offset_i);
    end else begin : g_branch_generic
      assign branch_tgt = branch_base_i + (branch_offset_i << 2);
    end
  endgenerate

  assign jr_tgt = {jr_target_i[WIDTH-1:2], 2'b00};

  always_comb begin
    next_pc_o  = pc_plus4_i;
    redirect_o = 1'b0;
    misalign_o = 1'b0;
    if (jr_i) begin
      next_pc_o  = jr_tgt;
      redirect_o = 1'b1;
      misalign_o = |jr_target_i[1:0];
    end else if (jump_i) begin
      next_pc_o  = jump_tgt;
      redirect_o = 1'b1;
    end else if (branch_taken_i) begin
      next_pc_o  = branch_tgt;
      redirect_o = 1'b1;
    end else if (stall_i) begin
      next_pc_o  = pc_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-PC register, BOOT/RUN/REDIR control, flush and addr_err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH    = PC_W,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_base,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             addr_err
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             addr_err_q, addr_err_d;

  logic [WIDTH-1:0] mux_next_pc;
  logic             mux_redirect;
  logic             mux_misalign;

  assign pc_plus4 = pc_q + WIDTH'(4);

  next_pc_mux #(
    .WIDTH (WIDTH)
  ) u_next_pc_mux (
    .pc_i            (pc_q),
    .pc_plus4_i      (pc_plus4),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_base_i   (branch_base),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .jr_i            (jr),
    .jr_target_i     (jr_target),
    .next_pc_o       (mux_next_pc),
    .redirect_o      (mux_redirect),
    .misalign_o      (mux_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_err_d = addr_err_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIR: begin
        pc_d    = mux_next_pc;
        state_d = mux_redirect ? REDIR : RUN;
        if (mux_misalign) begin
          addr_err_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Only fetch_valid sees an input combinationally (stall, in RUN).
  assign pc_out      = pc_q;
  assign fetch_valid = (state_q == RUN) && !stall;
  assign flush       = (state_q == REDIR);
  assign addr_err    = addr_err_q;

endmodule

`default_nettype wire
